// File: rtl/mips_multicycle_sequencer.sv
// mips_multicycle_sequencer: multicycle MIPS state sequencer with Avalon stalls, MULT/DIV wait and halt on jump-to-zero
// Ports: clk, reset_n (async active-low); opcode/func_code/rt_code instruction fields;
//   waitrequest (Avalon); jump_target_zero (resolved target is 0); state (to control decoder);
//   read/write (Avalon strobes); stall; muldiv_start; hilo_write; active (low once halted)
module mips_multicycle_sequencer #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] func_code,
  input  logic [4:0] rt_code,
  input  logic       waitrequest,
  input  logic       jump_target_zero,
  output logic [2:0] state,
  output logic       read,
  output logic       write,
  output logic       stall,
  output logic       muldiv_start,
  output logic       hilo_write,
  output logic       active
);
  localparam logic [2:0] FETCH = 3'd0, DECODE = 3'd1, EXECUTE = 3'd2, MEMORY_ACCESS = 3'd3,
    WRITE_BACK = 3'd4, MULDIV_WAIT = 3'd5, HALTED = 3'd6;
  logic [2:0] state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic r_type, r_known, is_mul, is_div, is_hilo, is_jump, is_load, is_store, is_mem_class;
  logic mul_wait, div_wait;
  assign r_type = opcode == 6'h00;
  assign is_mul = r_type && (func_code == 6'h18 || func_code == 6'h19);
  assign is_div = r_type && (func_code == 6'h1a || func_code == 6'h1b);
  assign is_hilo = r_type && (func_code == 6'h11 || func_code == 6'h13);
  // R-type encodings that pass through MEMORY_ACCESS (shifts, JR/JALR, MFHI/MFLO, ALU ops)
  assign r_known = r_type && (func_code inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08,
    6'h09, 6'h10, 6'h12, [6'h20:6'h27], 6'h2a, 6'h2b});
  assign is_jump = (r_type && (func_code == 6'h08 || func_code == 6'h09)) ||
    (opcode == 6'h01 && rt_code inside {5'h00, 5'h01, 5'h10, 5'h11}) || opcode inside {[6'h02:6'h07]};
  assign is_load = opcode inside {[6'h20:6'h26]};
  assign is_store = opcode inside {6'h28, 6'h29, 6'h2b};
  assign is_mem_class = r_known || is_jump || is_load || is_store || opcode inside {[6'h08:6'h0f]};
  assign mul_wait = is_mul && (MUL_CYCLES > 0);
  assign div_wait = is_div && (DIV_CYCLES > 0);
  // reset_n gates read so no strobe is visible while reset is held
  assign read = reset_n && (state == FETCH || (state == MEMORY_ACCESS && is_load));
  assign write = state == MEMORY_ACCESS && is_store;
  assign stall = (read || write) && waitrequest;
  assign active = state != HALTED;
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    muldiv_start = 1'b0;
    hilo_write = 1'b0;
    case (state)
      FETCH: state_nxt = waitrequest ? FETCH : DECODE;
      DECODE: state_nxt = EXECUTE;
      EXECUTE: begin
        if (mul_wait || div_wait) begin
          state_nxt = MULDIV_WAIT;
          cnt_nxt = mul_wait ? CNT_W'(MUL_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
          muldiv_start = 1'b1;
        end else if (is_mul || is_div || is_hilo) begin
          state_nxt = FETCH;
          hilo_write = 1'b1;
        end else state_nxt = is_mem_class ? MEMORY_ACCESS : FETCH;
      end
      MULDIV_WAIT: begin
        cnt_nxt = cnt == '0 ? cnt : cnt - 1'b1;
        hilo_write = cnt == '0;
        state_nxt = cnt == '0 ? FETCH : MULDIV_WAIT;
      end
      MEMORY_ACCESS: state_nxt = (is_load || is_store) ? (waitrequest ? MEMORY_ACCESS : is_load ? WRITE_BACK : FETCH)
                                                        : (is_jump && jump_target_zero ? HALTED : FETCH);
      WRITE_BACK: state_nxt = FETCH;
      HALTED: state_nxt = HALTED;
      default: state_nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// tb_mips_multicycle_sequencer: self-checking bench for mips_multicycle_sequencer
// Two instances share the inputs: index 0 uses MUL_CYCLES=4/DIV_CYCLES=32, index 1 uses 0/0.
// Each has its own reset; only the instance under test is checked at any time.
module tb_mips_multicycle_sequencer;
  localparam int C_NOP = 0, C_ALU = 1, C_JMP = 2, C_LD = 3, C_ST = 4, C_HILO = 5, C_MUL = 6, C_DIV = 7;
  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_B = 3'd4, S_W = 3'd5, S_H = 3'd6;
  typedef struct {bit wr; bit jtz; logic [8:0] exp;} step_t;
  typedef struct {logic [5:0] op; logic [5:0] fn; logic [4:0] rt; int cyc;} vec_t;
  logic clk = 1'b0;
  logic [1:0] rn = 2'b00;
  logic [5:0] opcode = 6'h00, func_code = 6'h00;
  logic [4:0] rt_code = 5'h00;
  logic waitrequest = 1'b0, jtz = 1'b0;
  logic [2:0] st [2];
  logic rd [2], wt [2], stl [2], ms [2], hw [2], act [2];
  logic [8:0] obs [2];
  step_t q [$];
  vec_t tbl [15];
  int n_chk = 0, n_fail = 0;
  int n_wait, n_ms, n_hw, n_stall, n_wr, n_wb, n_rdma;
  logic [5:0] ops [18] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                           6'h23, 6'h20, 6'h26, 6'h2b, 6'h28, 6'h0f, 6'h09, 6'h3f, 6'h30};
  logic [5:0] fns [12] = '{6'h21, 6'h18, 6'h19, 6'h1a, 6'h1b, 6'h11, 6'h13, 6'h08, 6'h09, 6'h01, 6'h0c, 6'h25};
  logic [4:0] rts [6] = '{5'd0, 5'd1, 5'd16, 5'd17, 5'd2, 5'd31};
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mips_multicycle_sequencer #(.MUL_CYCLES(g == 0 ? 4 : 0), .DIV_CYCLES(g == 0 ? 32 : 0), .CNT_W(6)) dut (
      .clk(clk), .reset_n(rn[g]), .opcode(opcode), .func_code(func_code), .rt_code(rt_code),
      .waitrequest(waitrequest), .jump_target_zero(jtz), .state(st[g]), .read(rd[g]), .write(wt[g]),
      .stall(stl[g]), .muldiv_start(ms[g]), .hilo_write(hw[g]), .active(act[g]));
    assign obs[g] = {st[g], rd[g], wt[g], stl[g], ms[g], hw[g], act[g]};
  end
  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    end
  endtask
  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction
  function automatic int cls(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    if (op == 6'h00) begin
      if (fn == 6'h18 || fn == 6'h19) return C_MUL;
      if (fn == 6'h1a || fn == 6'h1b) return C_DIV;
      if (fn == 6'h11 || fn == 6'h13) return C_HILO;
      if (fn == 6'h08 || fn == 6'h09) return C_JMP;
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12, 6'h2a, 6'h2b} ||
          (fn >= 6'h20 && fn <= 6'h27)) return C_ALU;
      return C_NOP;
    end
    if (op == 6'h01) return (rt == 5'd0 || rt == 5'd1 || rt == 5'd16 || rt == 5'd17) ? C_JMP : C_NOP;
    if (op >= 6'h02 && op <= 6'h07) return C_JMP;
    if (op >= 6'h08 && op <= 6'h0f) return C_ALU;
    if (op >= 6'h20 && op <= 6'h26) return C_LD;
    if (op == 6'h28 || op == 6'h29 || op == 6'h2b) return C_ST;
    return C_NOP;
  endfunction
  task automatic push(input bit wr, input bit jz, input logic [2:0] s, input bit r, input bit w,
                      input bit m, input bit h, input bit a);
    step_t e;
    e.wr = wr;
    e.jtz = jz;
    e.exp = {s, r, w, (r | w) & wr, m, h, a};
    q.push_back(e);
  endtask
  // Expected per-cycle trace of one instruction, built phase by phase from the instruction class
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt, input int fw,
                       input int mw, input bit halt, input int mc, input int dc);
    int c, n;
    bit ld, sw;
    c = cls(op, fn, rt);
    n = c == C_MUL ? mc : c == C_DIV ? dc : 0;
    ld = c == C_LD;
    sw = c == C_ST;
    q.delete();
    for (int i = 0; i < fw; i++) push(1'b1, rb(), S_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(1'b0, rb(), S_F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    push(rb(), rb(), S_D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (n > 0) begin
      push(rb(), rb(), S_E, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < n; i++) push(rb(), rb(), S_W, 1'b0, 1'b0, 1'b0, i == n - 1, 1'b1);
    end else push(rb(), rb(), S_E, 1'b0, 1'b0, 1'b0, c == C_MUL || c == C_DIV || c == C_HILO, 1'b1);
    if (c == C_ALU) push(rb(), rb(), S_M, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    if (c == C_JMP) begin
      push(rb(), halt, S_M, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (halt) for (int i = 0; i < 3; i++) push(rb(), rb(), S_H, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    if (ld || sw) begin
      for (int i = 0; i < mw; i++) push(1'b1, rb(), S_M, ld, sw, 1'b0, 1'b0, 1'b1);
      push(1'b0, rb(), S_M, ld, sw, 1'b0, 1'b0, 1'b1);
      if (ld) push(rb(), rb(), S_B, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
  endtask
  task automatic run(input int d, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    opcode = op;
    func_code = fn;
    rt_code = rt;
    foreach (q[i]) begin
      waitrequest = q[i].wr;
      jtz = q[i].jtz;
      #2;
      chk($sformatf("trace d%0d op%0h fn%0h rt%0h step%0d", d, op, fn, rt, i), int'(obs[d]), int'(q[i].exp));
      n_wait += int'(st[d] == S_W);
      n_wb += int'(st[d] == S_B);
      n_rdma += int'(rd[d] && st[d] == S_M);
      n_ms += int'(ms[d]);
      n_hw += int'(hw[d]);
      n_stall += int'(stl[d]);
      n_wr += int'(wt[d]);
      @(posedge clk);
      #1;
    end
    waitrequest = 1'b0;
    jtz = 1'b0;
  endtask
  task automatic clr();
    n_wait = 0; n_wb = 0; n_rdma = 0; n_ms = 0; n_hw = 0; n_stall = 0; n_wr = 0;
  endtask
  task automatic do_reset(input int d);
    rn[d] = 1'b0;
    @(posedge clk);
    #1;
    rn[d] = 1'b1;
  endtask
  task automatic exec(input int d, input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                      input int fw, input int mw, input bit halt);
    build(op, fn, rt, fw, mw, halt, d == 0 ? 4 : 0, d == 0 ? 32 : 0);
    run(d, op, fn, rt);
    if (halt && cls(op, fn, rt) == C_JMP) do_reset(d);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    logic [5:0] op, fn;
    tbl = '{'{6'h00, 6'h21, 5'd0, 4}, '{6'h23, 6'h00, 5'd0, 5}, '{6'h2b, 6'h00, 5'd0, 4},
            '{6'h00, 6'h18, 5'd0, 7}, '{6'h00, 6'h1b, 5'd0, 35}, '{6'h00, 6'h11, 5'd0, 3},
            '{6'h02, 6'h00, 5'd0, 4}, '{6'h04, 6'h00, 5'd0, 4}, '{6'h01, 6'h00, 5'd0, 4},
            '{6'h01, 6'h00, 5'd2, 3}, '{6'h00, 6'h01, 5'd0, 3}, '{6'h3f, 6'h00, 5'd0, 3},
            '{6'h0f, 6'h00, 5'd0, 4}, '{6'h00, 6'h08, 5'd0, 4}, '{6'h00, 6'h0c, 5'd0, 3}};
    #1;
    chk("reset d0", int'(obs[0]), 'h001);
    chk("reset d1", int'(obs[1]), 'h001);
    @(posedge clk);
    #1;
    rn[0] = 1'b1;
    for (int i = 0; i < 15; i++) begin
      opcode = tbl[i].op;
      func_code = tbl[i].fn;
      rt_code = tbl[i].rt;
      n = 0;
      do begin
        @(posedge clk);
        #1;
        n++;
      end while (st[0] != S_F && n < 100);
      chk($sformatf("length op%0h fn%0h rt%0h", tbl[i].op, tbl[i].fn, tbl[i].rt), n, tbl[i].cyc);
    end
    clr();
    exec(0, 6'h00, 6'h21, 5'd0, 0, 0, 1'b0);
    chk("addu read cycles", n_rdma, 0);
    clr();
    exec(0, 6'h23, 6'h00, 5'd0, 0, 3, 1'b0);
    chk("lw stall", n_stall, 3);
    chk("lw mem read", n_rdma, 4);
    chk("lw writeback", n_wb, 1);
    clr();
    exec(0, 6'h00, 6'h1b, 5'd0, 0, 0, 1'b0);
    chk("divu wait", n_wait, 32);
    chk("divu start", n_ms, 1);
    chk("divu hilo", n_hw, 1);
    clr();
    exec(0, 6'h2b, 6'h00, 5'd0, 2, 1, 1'b0);
    chk("sw write", n_wr, 2);
    chk("sw stall", n_stall, 3);
    chk("sw mem read", n_rdma, 0);
    chk("sw writeback", n_wb, 0);
    build(6'h00, 6'h08, 5'd0, 0, 0, 1'b1, 4, 32);
    run(0, 6'h00, 6'h08, 5'd0);
    opcode = 6'h23;
    waitrequest = 1'b1;
    jtz = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("halt hold", int'(obs[0]), 'h180);
    waitrequest = 1'b0;
    jtz = 1'b0;
    do_reset(0);
    opcode = 6'h00;
    func_code = 6'h18;
    repeat (4) @(posedge clk);
    #1;
    chk("mult in wait", int'(st[0]), int'(S_W));
    rn[0] = 1'b0;
    #1;
    chk("async reset", int'(obs[0]), 'h001);
    @(posedge clk);
    #1;
    chk("reset held", int'(obs[0]), 'h001);
    rn[0] = 1'b1;
    #1;
    chk("first fetch", int'(obs[0]), 'h021);
    @(posedge clk);
    #1;
    chk("after fetch", int'(st[0]), int'(S_D));
    n = 0;
    while (st[0] != S_F && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("mult drain", n, 6);
    for (int k = 0; k < 120; k++) begin
      op = ops[$urandom_range(0, 17)];
      fn = $urandom_range(0, 7) == 0 ? 6'($urandom) : fns[$urandom_range(0, 11)];
      exec(0, op, fn, rts[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 3) == 0);
    end
    do_reset(1);
    clr();
    exec(1, 6'h00, 6'h1b, 5'd0, 0, 0, 1'b0);
    chk("divu0 wait", n_wait, 0);
    chk("divu0 start", n_ms, 0);
    chk("divu0 hilo", n_hw, 1);
    clr();
    exec(1, 6'h00, 6'h18, 5'd0, 1, 0, 1'b0);
    chk("mult0 hilo", n_hw, 1);
    for (int k = 0; k < 60; k++) begin
      op = ops[$urandom_range(0, 17)];
      fn = $urandom_range(0, 7) == 0 ? 6'($urandom) : fns[$urandom_range(0, 11)];
      exec(1, op, fn, rts[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2),
           $urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
